// File: rtl/clb_ff_bank_if.sv
//------------------------------------------------------------------------------
// Module      : clb_ff_bank_if
// Description : Bundles the configuration-chain and data signals of the
//               clb_ff_bank flip-flop bank.
//               cfg_en    - shift the configuration chain, freeze data flops
//               ccff_head - serial configuration data in
//               ccff_tail - serial configuration data out
//               ff_ce     - data flop clock enable, active high
//               ff_set    - synchronous set, active high
//               ff_D      - data inputs  [WIDTH-1:0]
//               ff_Q      - data outputs [WIDTH-1:0]
//               Modport master drives the bank; modport slave is the bank.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface clb_ff_bank_if #(
  parameter int WIDTH = 4
);

  logic             cfg_en;
  logic             ccff_head;
  logic             ccff_tail;
  logic             ff_ce;
  logic             ff_set;
  logic [WIDTH-1:0] ff_D;
  logic [WIDTH-1:0] ff_Q;

  modport master (
    output cfg_en,
    output ccff_head,
    input  ccff_tail,
    output ff_ce,
    output ff_set,
    output ff_D,
    input  ff_Q
  );

  modport slave (
    input  cfg_en,
    input  ccff_head,
    output ccff_tail,
    input  ff_ce,
    input  ff_set,
    input  ff_D,
    output ff_Q
  );

endinterface : clb_ff_bank_if

`default_nettype wire

// File: rtl/clb_ff_bank.sv
//------------------------------------------------------------------------------
// Module      : clb_ff_bank
// Description : Bank of WIDTH configurable flip-flops placed after the LUT
//               outputs of a logic-block tile. Each bit has a 2-bit mode and
//               a reset-init value, loaded through a serial configuration
//               chain (3 bits per flop).
//               Modes: 00 D-FF, 01 T-FF, 10 bypass (Q = D combinationally),
//                      11 hold (Q frozen except by reset).
// Ports       : clk   - fabric clock, rising edge
//               reset - synchronous, active-low reset of the data flops
//               bus   - clb_ff_bank_if.slave (config chain + data signals)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clb_ff_bank #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  clb_ff_bank_if.slave  bus
);

  // Chain length is derived from the bank width (3 bits per flop).
  localparam int CFG_BITS = 3 * WIDTH;

  localparam logic [1:0] c_MODE_DFF    = 2'b00;
  localparam logic [1:0] c_MODE_TFF    = 2'b01;
  localparam logic [1:0] c_MODE_BYPASS = 2'b10;
  localparam logic [1:0] c_MODE_HOLD   = 2'b11;

  //----------------------------------------------------------------------------
  // Configuration chain. Deliberately has no reset: the bitstream must
  // survive a user reset of the data flops.
  //----------------------------------------------------------------------------
  logic [CFG_BITS-1:0] r_cfg;

  always_ff @(posedge clk) begin
    if (bus.cfg_en) begin
      r_cfg <= {r_cfg[CFG_BITS-2:0], bus.ccff_head};
    end
  end

  assign bus.ccff_tail = r_cfg[CFG_BITS-1];

  //----------------------------------------------------------------------------
  // Per-bit field decode: bit i owns r_cfg[3i+2:3i] = {init, mode[1:0]}.
  //----------------------------------------------------------------------------
  logic [WIDTH-1:0] w_init;
  logic [WIDTH-1:0] w_is_dff;
  logic [WIDTH-1:0] w_is_tff;
  logic [WIDTH-1:0] w_is_bypass;
  logic [WIDTH-1:0] w_is_hold;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
    logic [1:0] w_mode;

    assign w_mode          = r_cfg[3*gi +: 2];
    assign w_init[gi]      = r_cfg[3*gi + 2];
    assign w_is_dff[gi]    = (w_mode == c_MODE_DFF);
    assign w_is_tff[gi]    = (w_mode == c_MODE_TFF);
    assign w_is_bypass[gi] = (w_mode == c_MODE_BYPASS);
    assign w_is_hold[gi]   = (w_mode == c_MODE_HOLD);
  end : g_decode

  //----------------------------------------------------------------------------
  // Data flop next-state. Reset and the config freeze are applied in the
  // register process; here only the per-mode priority set > enable > hold.
  // Bypass bits still track D under the enable so that switching a bit out of
  // bypass starts from a sensible value.
  //----------------------------------------------------------------------------
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_is_hold[i]) begin
        w_q_next[i] = r_q[i];
      end else if (bus.ff_set) begin
        w_q_next[i] = 1'b1;
      end else if (bus.ff_ce) begin
        if (w_is_tff[i]) begin
          w_q_next[i] = r_q[i] ^ bus.ff_D[i];
        end else if (w_is_dff[i] || w_is_bypass[i]) begin
          w_q_next[i] = bus.ff_D[i];
        end else begin
          w_q_next[i] = r_q[i];
        end
      end
    end
  end

  // Reset outranks the config freeze: a reset during shifting loads the init
  // bits as they stood before this edge's shift.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= w_init;
    end else if (!bus.cfg_en) begin
      r_q <= w_q_next;
    end
  end

  //----------------------------------------------------------------------------
  // Output select: bypass bits are the only combinational D-to-Q path.
  //----------------------------------------------------------------------------
  assign bus.ff_Q = (w_is_bypass & bus.ff_D) | (~w_is_bypass & r_q);

endmodule : clb_ff_bank

`default_nettype wire

// File: tb/tb_clb_ff_bank.sv
//------------------------------------------------------------------------------
// Module      : tb_clb_ff_bank
// Description : Directed self-checking bench for clb_ff_bank (WIDTH=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clb_ff_bank;

  localparam int WIDTH = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  clb_ff_bank_if #(.WIDTH(WIDTH)) bus ();

  clb_ff_bank #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a config word from per-bit init and mode fields.
  function automatic logic [11:0] mk_cfg(input logic [3:0] init, input logic [7:0] mode);
    logic [11:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[3*i+2]    = init[i];
      c[3*i +: 2] = mode[2*i +: 2];
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift a 12-bit word MSB first so it ends up as cfg[11:0] = pat.
  task automatic program_cfg(input logic [11:0] pat);
    for (int k = 11; k >= 0; k--) begin
      bus.cfg_en    = 1'b1;
      bus.ccff_head = pat[k];
      step();
    end
    bus.cfg_en    = 1'b0;
    bus.ccff_head = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_config_chain();
    logic [11:0] pat;
    logic        exp_tail;
    pat = 12'b101_100_001_000;
    program_cfg(12'b0);
    for (int k = 11; k >= 0; k--) begin
      bus.cfg_en    = 1'b1;
      bus.ccff_head = pat[k];
      step();
      exp_tail = (k == 0) ? 1'b1 : 1'b0;
      if (bus.ccff_tail !== exp_tail) begin
        n_err++;
        $display("FAIL chain_fill shift %0d: tail=%b expected %b", 12 - k, bus.ccff_tail, exp_tail);
      end
      n_vec++;
    end
    // Shift zeros behind it: the tail must replay the pattern MSB first.
    for (int s = 0; s < 12; s++) begin
      if (bus.ccff_tail !== pat[11-s]) begin
        n_err++;
        $display("FAIL chain_replay bit %0d: tail=%b expected %b", s, bus.ccff_tail, pat[11-s]);
      end
      n_vec++;
      bus.cfg_en    = 1'b1;
      bus.ccff_head = 1'b0;
      step();
    end
    bus.cfg_en = 1'b0;
  endtask

  task automatic test_reset_dff();
    program_cfg(mk_cfg(4'b1010, 8'b00_00_00_00));
    pulse_reset();
    if (bus.ff_Q !== 4'b1010) begin
      n_err++; $display("FAIL reset_init: Q=%b expected 1010", bus.ff_Q);
    end
    n_vec++;
    if (bus.ccff_tail !== 1'b1) begin
      n_err++; $display("FAIL reset_tail: tail=%b expected 1", bus.ccff_tail);
    end
    n_vec++;
    bus.ff_D  = 4'b0110;
    bus.ff_ce = 1'b1;
    #1;
    if (bus.ff_Q !== 4'b1010) begin
      n_err++; $display("FAIL dff_no_comb: Q=%b expected 1010", bus.ff_Q);
    end
    n_vec++;
    step();
    if (bus.ff_Q !== 4'b0110) begin
      n_err++; $display("FAIL dff_load: Q=%b expected 0110", bus.ff_Q);
    end
    n_vec++;
    bus.ff_ce = 1'b0;
    bus.ff_D  = 4'b1111;
    step();
    if (bus.ff_Q !== 4'b0110) begin
      n_err++; $display("FAIL dff_ce_low: Q=%b expected 0110", bus.ff_Q);
    end
    n_vec++;
  endtask

  task automatic test_toggle();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b0011;
    exp_seq[1] = 4'b0000;
    exp_seq[2] = 4'b0011;
    bus.ff_ce = 1'b0;
    bus.ff_D  = 4'b0000;
    program_cfg(mk_cfg(4'b0000, 8'b01_01_01_01));
    pulse_reset();
    if (bus.ff_Q !== 4'b0000) begin
      n_err++; $display("FAIL tff_reset: Q=%b expected 0000", bus.ff_Q);
    end
    n_vec++;
    bus.ff_D  = 4'b0011;
    bus.ff_ce = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      if (bus.ff_Q !== exp_seq[e]) begin
        n_err++; $display("FAIL tff_edge%0d: Q=%b expected %b", e, bus.ff_Q, exp_seq[e]);
      end
      n_vec++;
    end
    bus.ff_set = 1'b1;
    step();
    if (bus.ff_Q !== 4'b1111) begin
      n_err++; $display("FAIL tff_set: Q=%b expected 1111", bus.ff_Q);
    end
    n_vec++;
    bus.ff_set = 1'b0;
    bus.ff_ce  = 1'b0;
  endtask

  task automatic test_bypass_hold();
    bus.ff_D = 4'b0000;
    // bit0 bypass init0, bit1 hold init1, bits3/2 D-FF init0
    program_cfg(mk_cfg(4'b0010, 8'b00_00_11_10));
    pulse_reset();
    if (bus.ff_Q !== 4'b0010) begin
      n_err++; $display("FAIL bh_reset: Q=%b expected 0010", bus.ff_Q);
    end
    n_vec++;
    bus.ff_D = 4'b0001;
    #1;
    if (bus.ff_Q !== 4'b0011) begin
      n_err++; $display("FAIL bypass_rise: Q=%b expected 0011", bus.ff_Q);
    end
    n_vec++;
    bus.ff_D = 4'b0000;
    #1;
    if (bus.ff_Q !== 4'b0010) begin
      n_err++; $display("FAIL bypass_fall: Q=%b expected 0010", bus.ff_Q);
    end
    n_vec++;
    bus.ff_ce = 1'b1;
    step();
    if (bus.ff_Q !== 4'b0010) begin
      n_err++; $display("FAIL hold_ce: Q=%b expected 0010", bus.ff_Q);
    end
    n_vec++;
    bus.ff_set = 1'b1;
    bus.ff_D   = 4'b0001;
    step();
    if (bus.ff_Q !== 4'b1111) begin
      n_err++; $display("FAIL hold_set: Q=%b expected 1111", bus.ff_Q);
    end
    n_vec++;
    bus.ff_set = 1'b0;
    bus.ff_ce  = 1'b0;
    bus.ff_D   = 4'b0000;
  endtask

  task automatic test_cfg_freeze();
    program_cfg(12'b0);
    pulse_reset();
    bus.cfg_en    = 1'b1;
    bus.ccff_head = 1'b0;
    bus.ff_ce     = 1'b1;
    bus.ff_set    = 1'b1;
    bus.ff_D      = 4'b0101;
    for (int e = 0; e < 2; e++) begin
      step();
      if (bus.ff_Q !== 4'b0000) begin
        n_err++; $display("FAIL freeze_edge%0d: Q=%b expected 0000", e, bus.ff_Q);
      end
      n_vec++;
    end
    bus.cfg_en = 1'b0;
    bus.ff_set = 1'b0;
    bus.ff_ce  = 1'b0;
    program_cfg(12'b100_000_100_000);
    bus.ff_ce = 1'b1;
    bus.ff_D  = 4'b0101;
    step();
    if (bus.ff_Q !== 4'b0101) begin
      n_err++; $display("FAIL freeze_preload: Q=%b expected 0101", bus.ff_Q);
    end
    n_vec++;
    bus.ff_ce = 1'b0;
    // Reset on a shift edge: q takes the pre-shift inits (1010), chain moves
    // to 000_001_000_001 whose inits are all zero.
    reset         = 1'b0;
    bus.cfg_en    = 1'b1;
    bus.ccff_head = 1'b1;
    step();
    reset         = 1'b1;
    bus.cfg_en    = 1'b0;
    bus.ccff_head = 1'b0;
    if (bus.ff_Q !== 4'b1010) begin
      n_err++; $display("FAIL rst_shift_q: Q=%b expected 1010", bus.ff_Q);
    end
    n_vec++;
    if (bus.ccff_tail !== 1'b0) begin
      n_err++; $display("FAIL rst_shift_tail: tail=%b expected 0", bus.ccff_tail);
    end
    n_vec++;
    pulse_reset();
    if (bus.ff_Q !== 4'b0000) begin
      n_err++; $display("FAIL rst_shift_newinit: Q=%b expected 0000", bus.ff_Q);
    end
    n_vec++;
  endtask

  task automatic test_priority();
    program_cfg(12'b100_000_100_000);
    bus.ff_ce = 1'b1;
    bus.ff_D  = 4'b0101;
    step();
    if (bus.ff_Q !== 4'b0101) begin
      n_err++; $display("FAIL prio_preload: Q=%b expected 0101", bus.ff_Q);
    end
    n_vec++;
    bus.ff_set = 1'b1;
    reset      = 1'b0;
    step();
    if (bus.ff_Q !== 4'b1010) begin
      n_err++; $display("FAIL prio_reset_wins: Q=%b expected 1010", bus.ff_Q);
    end
    n_vec++;
    reset = 1'b1;
    step();
    if (bus.ff_Q !== 4'b1111) begin
      n_err++; $display("FAIL prio_set_after: Q=%b expected 1111", bus.ff_Q);
    end
    n_vec++;
    bus.ff_set = 1'b0;
    bus.ff_ce  = 1'b0;
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    reset         = 1'b1;
    bus.cfg_en    = 1'b0;
    bus.ccff_head = 1'b0;
    bus.ff_ce     = 1'b0;
    bus.ff_set    = 1'b0;
    bus.ff_D      = 4'b0000;
    step();
    test_config_chain();
    test_reset_dff();
    test_toggle();
    test_bypass_hold();
    test_cfg_freeze();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_clb_ff_bank

`default_nettype wire
